// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t   : controller states IDLE -> RUN -> DONE -> IDLE
//   cnt_width : width of a step counter that has to count to `width`
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/add_sub_nbit.sv
// N-bit adder/subtractor, the parametrised form of the legacy 4-bit adder.
// Ports:
//   a, b   : N-bit operands
//   sub    : 0 -> result = a + b, 1 -> result = a - b (modulo 2^N)
//   result : N-bit result, carry-out discarded
module add_sub_nbit #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] result
);

  // Two's-complement subtract: invert b and inject the +1 as carry-in.
  assign result = a + (b ^ {N{sub}}) + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock through a
// single (WIDTH+1)-bit adder, behind a start/done handshake.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   start     : operation request, sampled only in IDLE
//   a, b      : multiplicand / multiplier, captured on the accepted start
//   signed_op : (SEQ_MULT_SIGNED_EN only) 1 = two's-complement operands
//   busy      : high from the accepted start through the done cycle
//   done      : one-cycle pulse, product valid
//   product   : 2*WIDTH-bit result, held until the next operation completes
// Configuration macro: SEQ_MULT_SIGNED_EN enables the signed_op port and the
// signed datapath (sign extension + final-step subtract).
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 signed_op,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state, state_n;
  logic [WIDTH-1:0]   mcand, mcand_n;
  logic [WIDTH-1:0]   hi, hi_n;
  logic [WIDTH-1:0]   lo, lo_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2*WIDTH-1:0] product_n;
  logic               busy_n, done_n;

  logic               last;
  logic               ext_h, ext_m, add_sub;
  logic [WIDTH:0]     add_x, add_y, sum;

`ifdef SEQ_MULT_SIGNED_EN
  logic               sgn, sgn_n;
`endif

  assign last = (cnt == LAST);

  // Operand shaping for the single adder. In the signed case the running
  // high half is itself signed, so both adder inputs are sign-extended and
  // the multiplier MSB (final step) carries negative weight.
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    ext_h   = sgn & hi[WIDTH-1];
    ext_m   = sgn & mcand[WIDTH-1];
    add_sub = sgn & last;
`else
    ext_h   = 1'b0;
    ext_m   = 1'b0;
    add_sub = 1'b0;
`endif
    add_x = {ext_h, hi};
    add_y = lo[0] ? {ext_m, mcand} : '0;
  end

  add_sub_nbit #(
    .N(WIDTH + 1)
  ) u_add (
    .a      (add_x),
    .b      (add_y),
    .sub    (add_sub),
    .result (sum)
  );

  always_comb begin
    state_n   = state;
    mcand_n   = mcand;
    hi_n      = hi;
    lo_n      = lo;
    cnt_n     = cnt;
    product_n = product;
    done_n    = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    sgn_n     = sgn;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          mcand_n = a;
          hi_n    = '0;
          lo_n    = b;
          cnt_n   = '0;
`ifdef SEQ_MULT_SIGNED_EN
          sgn_n   = signed_op;
`endif
          state_n = RUN;
        end
      end
      RUN: begin
        // {sum, lo} >> 1 truncated to 2*WIDTH bits; the shifted-in fill bit
        // falls off the top, so logical vs arithmetic only shows in sum[WIDTH].
        hi_n  = sum[WIDTH:1];
        lo_n  = {sum[0], lo[WIDTH-1:1]};
        cnt_n = cnt + 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        product_n = {hi, lo};
        done_n    = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // busy is registered: it also covers the cycle in which done is high.
    busy_n = (state_n != IDLE) || (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      sgn     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      mcand   <= mcand_n;
      hi      <= hi_n;
      lo      <= lo_n;
      cnt     <= cnt_n;
      product <= product_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef SEQ_MULT_SIGNED_EN
      sgn     <= sgn_n;
`endif
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a WIDTH=8 and a WIDTH=4 instance.
module tb_seq_multiplier;

  typedef struct {
    logic [15:0] prod;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start4;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic        busy8, done8, busy4, done4;
  logic [15:0] prod8;
  logic [7:0]  prod4;
`ifdef SEQ_MULT_SIGNED_EN
  logic        sop8;
`endif

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        q8[$];
  exp_t        q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .a         (a8),
    .b         (b8),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_op (sop8),
`endif
    .busy      (busy8),
    .done      (done8),
    .product   (prod8)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .a         (a4),
    .b         (b4),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_op (1'b0),
`endif
    .busy      (busy4),
    .done      (done4),
    .product   (prod4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop the scoreboard whenever a done pulse is presented.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("done8_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("product8", {16'd0, prod8}, {16'd0, e.prod});
        check("latency8", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        check("done4_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("product4", {24'd0, prod4}, {16'd0, e.prod});
        check("latency4", cyc, e.due);
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
    sop8 = s;
`else
    if (s) $display("note: signed request issued on unsigned build");
`endif
    q8.push_back('{prod: exp, due: cyc + 10});
    @(negedge clk);
    start8 = 1'b0;
    check("busy8_after_start", {31'd0, busy8}, 32'd1);
  endtask

  task automatic wait8();
    int unsigned n = 0;
    while (q8.size() != 0 && n < 30) begin
      @(negedge clk); #2;
      n++;
    end
    if (q8.size() != 0) begin
      check("timeout8", q8.size(), 32'd0);
      q8.delete();
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp);
    issue8(a, b, s, exp);
    wait8();
    check("busy8_in_done", {31'd0, busy8}, 32'd1);
    @(negedge clk);
    check("busy8_after_done", {31'd0, busy8}, 32'd0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    int unsigned n = 0;
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    q4.push_back('{prod: {8'd0, exp}, due: cyc + 6});
    @(negedge clk);
    start4 = 1'b0;
    check("busy4_after_start", {31'd0, busy4}, 32'd1);
    while (q4.size() != 0 && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    if (q4.size() != 0) begin
      check("timeout4", q4.size(), 32'd0);
      q4.delete();
    end
    @(negedge clk);
    check("busy4_after_done", {31'd0, busy4}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
`ifdef SEQ_MULT_SIGNED_EN
    sop8 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_product8", {16'd0, prod8}, 32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_product4", {24'd0, prod4}, 32'd0);
    rst = 1'b0;

    // Legacy 4x4 equivalence
    op4(4'hF, 4'hF, 8'hE1);
    op4(4'hA, 4'h3, 8'h1E);

    // Basic 8-bit vectors
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    op8(8'h00, 8'hA5, 1'b0, 16'h0000);
    op8(8'hFD, 8'h05, 1'b0, 16'h04F1);

    // start held high: accepts every 10 cycles; other-cycle operands ignored
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start8 = 1'b1;
      if (i % 10 == 0) begin
        a8 = 8'd3; b8 = 8'd7;
        q8.push_back('{prod: 16'd21, due: cyc + 10});
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    wait8();
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-RUN: abandoned operation never reports done
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_product8", {16'd0, prod8}, 32'd0);
    check("async_rst_busy8", {31'd0, busy8}, 32'd0);
    check("async_rst_done8", {31'd0, done8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_busy8", {31'd0, busy8}, 32'd0);
    op8(8'd2, 8'd3, 1'b0, 16'd6);

    // Product hold across a following RUN
    op8(8'd2, 8'd2, 1'b0, 16'd4);
    issue8(8'd3, 8'd3, 1'b0, 16'd9);
    check("hold_product8", {16'd0, prod8}, 32'd4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("hold_product8", {16'd0, prod8}, 32'd4);
    end
    wait8();
    @(negedge clk);

`ifdef SEQ_MULT_SIGNED_EN
    op8(8'h80, 8'h80, 1'b1, 16'h4000);
    op8(8'hFD, 8'h05, 1'b1, 16'hFFF1);
    op8(8'hFD, 8'h05, 1'b0, 16'h04F1);
`endif

    repeat (3) @(negedge clk);
    check("pending8", q8.size(), 32'd0);
    check("pending4", q4.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
